// File: rtl/skew_mes_ctl_mc.sv
// -----------------------------------------------------------------------------
// skew_mes_ctl_mc
//
// This block is the multi-channel skew measurement controller. It sweeps the
// shared comparator delay line upward from code 0 to find the master edge code.
// It then sweeps again from 0 for each enabled slave channel, in ascending
// channel order. Each channel reports a signed skew equal to the slave code
// minus the master code, so a slave that is early gives a negative result.
//
// Every delay step takes NSMP strobes. The step is a hit when the number of
// ones is greater than NSMP/2 (majority vote). Each strobe wait is limited by
// a timeout.
//
// Ports
//   clk_i         clock
//   arstn_i       asynchronous reset, active-low
//   run_i         start/hold; low returns to IDLE on the next cycle
//   ch_en_i       slave enable mask, captured when leaving IDLE
//   m_cmp_i       master comparator output
//   s_cmp_i       slave comparator outputs
//   stb_req_o     one-cycle strobe request (registered)
//   stb_valid_i   strobe done; comparator inputs are valid this cycle
//   delay_code_o  delay line code
//   ch_sel_o      0 = master, k = slave k-1
//   res_o         signed skews, channel k at [k*(DW+1) +: DW+1]
//   res_vld_o     per-channel result valid
//   busy_o        measurement in progress
//   rdy_o         all enabled channels measured
//   err_o         0 none, 1 master fail, 2 slave fail, 3 strobe timeout
//   err_ch_o      ch_sel_o value when the error was raised
// -----------------------------------------------------------------------------
module skew_mes_ctl_mc #(
  parameter int DW     = 10,
  parameter int NCH    = 4,
  parameter int NSMP   = 3,
  parameter int STB_TO = 1023
) (
  input  logic                     clk_i,
  input  logic                     arstn_i,
  input  logic                     run_i,
  input  logic [NCH-1:0]           ch_en_i,
  input  logic                     m_cmp_i,
  input  logic [NCH-1:0]           s_cmp_i,
  output logic                     stb_req_o,
  input  logic                     stb_valid_i,
  output logic [DW-1:0]            delay_code_o,
  output logic [$clog2(NCH+1)-1:0] ch_sel_o,
  output logic [NCH*(DW+1)-1:0]    res_o,
  output logic [NCH-1:0]           res_vld_o,
  output logic                     busy_o,
  output logic                     rdy_o,
  output logic [1:0]               err_o,
  output logic [$clog2(NCH+1)-1:0] err_ch_o
);

  localparam int CW = $clog2(NCH + 1);
  localparam int RW = DW + 1;
  localparam int SW = $clog2(NSMP + 1);
  localparam int TW = $clog2(STB_TO + 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] REQ_STB   = 3'd1;
  localparam logic [2:0] WAIT_STB  = 3'd2;
  localparam logic [2:0] DECIDE    = 3'd3;
  localparam logic [2:0] INC_DELAY = 3'd4;
  localparam logic [2:0] NEXT_CH   = 3'd5;
  localparam logic [2:0] READY     = 3'd6;
  localparam logic [2:0] ERR       = 3'd7;

  // Majority vote over the strobes taken at one delay step.
  function automatic logic maj_hit(input logic [SW-1:0] ones);
    return ones > SW'(NSMP / 2);
  endfunction

  // Both codes are widened with a zero MSB before subtracting. The master code
  // is never 0, so the signed difference fits in DW+1 bits and cannot wrap.
  function automatic logic signed [RW-1:0] skew_calc(input logic [DW-1:0] s_code,
                                                     input logic [DW-1:0] m_code);
    logic signed [RW-1:0] s_ext;
    logic signed [RW-1:0] m_ext;
    s_ext = signed'({1'b0, s_code});
    m_ext = signed'({1'b0, m_code});
    return s_ext - m_ext;
  endfunction

  // A failure on the master sweep is reported as code 1; a failure on any
  // slave sweep is reported as code 2.
  function automatic logic [1:0] fail_code(input logic [CW-1:0] sel);
    return (sel == '0) ? 2'd1 : 2'd2;
  endfunction

  logic [2:0]         state_q,   state_d;
  logic [DW-1:0]      code_q,    code_d;
  logic [DW-1:0]      m_code_q,  m_code_d;
  logic [CW-1:0]      ch_sel_q,  ch_sel_d;
  logic [NCH-1:0]     ch_en_q,   ch_en_d;
  logic [NCH*RW-1:0]  res_q,     res_d;
  logic [NCH-1:0]     res_vld_q, res_vld_d;
  logic [SW-1:0]      smp_q,     smp_d;
  logic [SW-1:0]      ones_q,    ones_d;
  logic [TW-1:0]      to_q,      to_d;
  logic               stb_req_q, stb_req_d;
  logic [1:0]         err_q,     err_d;
  logic [CW-1:0]      err_ch_q,  err_ch_d;

  logic               sel_cmp;
  logic               nxt_found;
  logic [CW-1:0]      nxt_sel;
  logic [SW-1:0]      smp_nxt;

  // Select the comparator output for the channel currently being swept.
  always_comb begin
    sel_cmp = m_cmp_i;
    for (int k = 0; k < NCH; k++) begin
      if (ch_sel_q == CW'(k + 1)) sel_cmp = s_cmp_i[k];
    end
  end

  // Find the lowest enabled slave after the current one. While ch_sel is k+1
  // (slave k), only slaves with index >= ch_sel are candidates. The loop runs
  // downward so that the lowest matching index is the last one assigned.
  always_comb begin
    nxt_found = 1'b0;
    nxt_sel   = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (ch_en_q[k] && (CW'(k) >= ch_sel_q)) begin
        nxt_found = 1'b1;
        nxt_sel   = CW'(k + 1);
      end
    end
  end

  assign smp_nxt = smp_q + SW'(1);

  // Next-state logic for the sweep controller.
  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    m_code_d  = m_code_q;
    ch_sel_d  = ch_sel_q;
    ch_en_d   = ch_en_q;
    res_d     = res_q;
    res_vld_d = res_vld_q;
    smp_d     = smp_q;
    ones_d    = ones_q;
    to_d      = to_q;
    stb_req_d = 1'b0;
    err_d     = err_q;
    err_ch_d  = err_ch_q;

    if (!run_i) begin
      // Abort from any state. Results are kept until the next start.
      state_d  = IDLE;
      code_d   = '0;
      ch_sel_d = '0;
      smp_d    = '0;
      ones_d   = '0;
      to_d     = '0;
      err_d    = 2'd0;
      err_ch_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          code_d    = '0;
          ch_sel_d  = '0;
          ch_en_d   = ch_en_i;
          res_d     = '0;
          res_vld_d = '0;
          smp_d     = '0;
          ones_d    = '0;
          state_d   = REQ_STB;
        end
        REQ_STB: begin
          stb_req_d = 1'b1;
          to_d      = '0;
          state_d   = WAIT_STB;
        end
        WAIT_STB: begin
          if (stb_valid_i) begin
            ones_d  = ones_q + SW'(sel_cmp);
            smp_d   = smp_nxt;
            state_d = (smp_nxt == SW'(NSMP)) ? DECIDE : REQ_STB;
          end else if (to_q == TW'(STB_TO - 1)) begin
            // This is the STB_TO-th cycle in WAIT_STB with no strobe.
            err_d    = 2'd3;
            err_ch_d = ch_sel_q;
            state_d  = ERR;
          end else begin
            to_d = to_q + TW'(1);
          end
        end
        DECIDE: begin
          smp_d  = '0;
          ones_d = '0;
          if (!maj_hit(ones_q)) begin
            state_d = INC_DELAY;
          end else if (code_q == '0) begin
            // A hit at code 0 means the sweep never saw the edge from below.
            err_d    = fail_code(ch_sel_q);
            err_ch_d = ch_sel_q;
            state_d  = ERR;
          end else begin
            if (ch_sel_q == '0) begin
              m_code_d = code_q;
            end else begin
              for (int k = 0; k < NCH; k++) begin
                if (ch_sel_q == CW'(k + 1)) begin
                  res_d[k*RW +: RW] = skew_calc(code_q, m_code_q);
                  res_vld_d[k]      = 1'b1;
                end
              end
            end
            state_d = NEXT_CH;
          end
        end
        INC_DELAY: begin
          if (code_q == {DW{1'b1}}) begin
            err_d    = fail_code(ch_sel_q);
            err_ch_d = ch_sel_q;
            state_d  = ERR;
          end else begin
            code_d  = code_q + DW'(1);
            state_d = REQ_STB;
          end
        end
        NEXT_CH: begin
          if (nxt_found) begin
            ch_sel_d = nxt_sel;
            code_d   = '0;
            state_d  = REQ_STB;
          end else begin
            state_d = READY;
          end
        end
        default: ;  // READY and ERR hold until run_i drops.
      endcase
    end
  end

  // ---- register stage: controller state and results ----
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q   <= IDLE;
      code_q    <= '0;
      m_code_q  <= '0;
      ch_sel_q  <= '0;
      ch_en_q   <= '0;
      res_q     <= '0;
      res_vld_q <= '0;
      smp_q     <= '0;
      ones_q    <= '0;
      to_q      <= '0;
      stb_req_q <= 1'b0;
      err_q     <= 2'd0;
      err_ch_q  <= '0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      m_code_q  <= m_code_d;
      ch_sel_q  <= ch_sel_d;
      ch_en_q   <= ch_en_d;
      res_q     <= res_d;
      res_vld_q <= res_vld_d;
      smp_q     <= smp_d;
      ones_q    <= ones_d;
      to_q      <= to_d;
      stb_req_q <= stb_req_d;
      err_q     <= err_d;
      err_ch_q  <= err_ch_d;
    end
  end

  assign stb_req_o    = stb_req_q;
  assign delay_code_o = code_q;
  assign ch_sel_o     = ch_sel_q;
  assign res_o        = res_q;
  assign res_vld_o    = res_vld_q;
  assign busy_o       = (state_q != IDLE) && (state_q != READY) && (state_q != ERR);
  assign rdy_o        = (state_q == READY);
  assign err_o        = err_q;
  assign err_ch_o     = err_ch_q;

endmodule
